runway_scheduler: RTL and testbench
===================================

# runway_scheduler

Arbitrates the two runways of the ATC core between the takeoff-queue head and the landing-queue head. It pops one plane at a time from the requesting FIFO and reserves the lowest-numbered free runway for it. It issues a grant toward the reply path and tracks runway ownership. A per-runway occupancy watchdog force-releases a runway whose owner never reports clear. It sits between the takeoff/landing FIFOs, the request decoder (release and emergency inputs) and the reply builder.

## Interface
- TIMEOUT_CYCLES, 1024: cycles a runway may stay owned before forced release; must be at least 2.
- STARVE_LIMIT, 3: consecutive landing grants made while a takeoff waits, after which takeoff wins the next tie.
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- to_valid  in  1  takeoff FIFO not empty.
- to_id  in  4  takeoff FIFO registered head output; valid the cycle after to_pop.
- to_pop  out  1  one-cycle pop of takeoff FIFO.
- ld_valid  in  1  landing FIFO not empty.
- ld_id  in  4  landing FIFO registered head output; valid the cycle after ld_pop.
- ld_pop  out  1  one-cycle pop of landing FIFO.
- emergency  in  1  level; takeoffs are not granted while high.
- rel_valid  in  1  runway-clear request, one cycle.
- rel_runway  in  1  runway being cleared.
- rel_id  in  4  plane claiming to clear it.
- grant_valid  out  1  grant pending.
- grant_id  out  4  granted plane.
- grant_runway  out  1  assigned runway.
- grant_landing  out  1  1 = landing, 0 = takeoff.
- grant_ready  in  1  reply path accepts grant.
- runway_busy  out  2  bit r = runway r reserved or owned.
- timeout_valid  out  1  one-cycle forced-release pulse.
- timeout_runway  out  1  runway forced free.
- timeout_id  out  4  owner that timed out.

## Operation
- FSM states: IDLE, LATCH, GRANT. Reset enters IDLE. All outputs, owners, timers and the starve counter are 0 on reset.
- IDLE: a pick happens when at least one runway is free and at least one class is eligible. Takeoff is eligible when to_valid && !emergency. Landing is eligible when ld_valid.
  - Runway choice: runway 0 if free, else runway 1.
  - Class choice: the only eligible class wins. If both are eligible, landing wins unless starve_cnt >= STARVE_LIMIT, in which case takeoff wins.
  - On a pick: pulse the matching pop (combinational, same cycle), set runway_busy[r] (reserved), latch class and runway, go to LATCH. Otherwise stay in IDLE.
- starve_cnt: increments (saturating) on a landing pick made while takeoff was eligible. Clears on any takeoff pick.
- LATCH: sample to_id or ld_id into the owner of r and into grant_id. Load timer[r] with TIMEOUT_CYCLES and mark r owned. Go to GRANT.
- GRANT: grant_valid = 1 and grant fields are stable. When grant_ready = 1, go to IDLE; grant_valid drops the next cycle. No new pick happens while in LATCH or GRANT.
- Release: applies when rel_valid, runway rel_runway is owned, and rel_id equals its owner. The runway frees at the next edge and its timer clears. Mismatched id, an unowned runway, or a runway that is only reserved (in LATCH) is ignored silently.
- Watchdog: each owned runway's timer decrements every cycle. When the timer is 1 and no valid release targets that runway this cycle:
  - the runway frees at the next edge;
  - timeout_valid, timeout_runway and timeout_id are driven for exactly that next cycle.
- Simultaneous events:
  - Release and expiry on the same runway: release wins, no timeout pulse.
  - Both runways expiring in the same cycle: runway 0 is reported first; runway 1 frees one cycle later, with its timer held at 1.
  - A release freeing a runway in the same cycle IDLE evaluates: the freed runway is not visible until the next cycle.
- Reset mid-operation: state returns to IDLE and all runways free. A plane already popped is dropped; the reply path must tolerate this.

## Timing
- Pick in cycle N. to_pop/ld_pop is high in N only. LATCH is N+1. grant_valid first rises in N+2.
- Minimum spacing between picks is 3 cycles: pick, LATCH, and GRANT accepted in the same cycle, then IDLE.
- Owned duration before forced free is exactly TIMEOUT_CYCLES cycles, counted from the LATCH edge. The timeout pulse is in the following cycle.
- Timer width is $clog2(TIMEOUT_CYCLES+1). No wrap is possible.

## Test plan
- Takeoff only: to_valid = 1, to_id = 5, emergency = 0 → to_pop in N; grant_valid at N+2 with id 5, runway 0, grant_landing = 0; runway_busy = 01.
- Both runways busy: grant planes 3 then 7 → runways 0 and 1. A third request stays in IDLE with no pop. Release (runway 0, id 3) → the third plane gets runway 0. Release (runway 1, id 9) → ignored, busy stays 11.
- Starvation, STARVE_LIMIT = 3: both queues always non-empty, runways released each grant → grant order landing, landing, landing, takeoff, landing, and so on.
- Emergency = 1 with both valid → only landings are popped and to_pop never asserts; after emergency clears, takeoff is granted.
- TIMEOUT_CYCLES = 8: grant id 2 on runway 0 with no release → timeout_valid pulses exactly once with runway 0, id 2, 9 cycles after the LATCH cycle; busy bit 0 clears.
- Release of id 2 in the expiry cycle → busy clears and no timeout pulse. Reset asserted during GRANT → grant_valid = 0 and runway_busy = 00 on the next cycle.

Source files
------------

// File: rtl/runway_scheduler.sv
// Two-runway scheduler: pops the takeoff or landing queue head, reserves the lowest
// free runway, issues a grant, and force-frees runways whose owners never report clear.
module runway_scheduler #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int STARVE_LIMIT   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       to_valid,
    input  logic [3:0] to_id,
    output logic       to_pop,
    input  logic       ld_valid,
    input  logic [3:0] ld_id,
    output logic       ld_pop,
    input  logic       emergency,
    input  logic       rel_valid,
    input  logic       rel_runway,
    input  logic [3:0] rel_id,
    output logic       grant_valid,
    output logic [3:0] grant_id,
    output logic       grant_runway,
    output logic       grant_landing,
    input  logic       grant_ready,
    output logic [1:0] runway_busy,
    output logic       timeout_valid,
    output logic       timeout_runway,
    output logic [3:0] timeout_id
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 2);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, LATCH, GRANT} state_t;

    state_t        state;
    logic [1:0]    reserved;
    logic [1:0]    owned;
    logic [3:0]    owner [2];
    logic [TW-1:0] timer [2];
    logic [SW-1:0] starve_cnt;

    logic [1:0] free;
    logic       to_eligible;
    logic       ld_eligible;
    logic       pick;
    logic       pick_landing;
    logic       pick_runway;
    logic       rel_hit;
    logic [1:0] expire;
    logic [1:0] forced_free;

    assign free        = ~(reserved | owned);
    assign runway_busy = reserved | owned;

    always_comb begin
        to_eligible  = to_valid && !emergency;
        ld_eligible  = ld_valid;
        pick         = !reset && (state == IDLE) && (free != 2'b00) && (to_eligible || ld_eligible);
        pick_landing = ld_eligible && (!to_eligible || (starve_cnt < STARVE_MAX));
        pick_runway  = !free[0];
        to_pop       = pick && !pick_landing;
        ld_pop       = pick && pick_landing;
        rel_hit      = rel_valid && owned[rel_runway] && (rel_id == owner[rel_runway]);
        // A matching release on the same runway beats expiry.
        expire[0]    = owned[0] && (timer[0] == TIMER_ONE) && !(rel_hit && !rel_runway);
        expire[1]    = owned[1] && (timer[1] == TIMER_ONE) && !(rel_hit && rel_runway);
        // Only one forced release per cycle; runway 1 waits with its timer parked at 1.
        forced_free  = {expire[1] && !expire[0], expire[0]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            reserved       <= 2'b00;
            owned          <= 2'b00;
            starve_cnt     <= '0;
            grant_valid    <= 1'b0;
            grant_id       <= 4'd0;
            grant_runway   <= 1'b0;
            grant_landing  <= 1'b0;
            timeout_valid  <= 1'b0;
            timeout_runway <= 1'b0;
            timeout_id     <= 4'd0;
            for (int r = 0; r < 2; r++) begin
                owner[r] <= 4'd0;
                timer[r] <= '0;
            end
        end else begin
            timeout_valid <= |forced_free;
            if (|forced_free) begin
                timeout_runway <= forced_free[1];
                timeout_id     <= forced_free[0] ? owner[0] : owner[1];
            end

            for (int r = 0; r < 2; r++) begin
                if ((rel_hit && (int'(rel_runway) == r)) || forced_free[r]) begin
                    owned[r] <= 1'b0;
                    timer[r] <= '0;
                end else if (owned[r] && (timer[r] > TIMER_ONE)) begin
                    timer[r] <= timer[r] - TIMER_ONE;
                end
            end

            case (state)
                IDLE: begin
                    if (pick) begin
                        reserved[pick_runway] <= 1'b1;
                        grant_runway          <= pick_runway;
                        grant_landing         <= pick_landing;
                        state                 <= LATCH;
                        if (!pick_landing) begin
                            starve_cnt <= '0;
                        end else if (to_eligible && (starve_cnt < STARVE_MAX)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    // The FIFO head register holds the popped plane in this cycle.
                    owner[grant_runway]    <= grant_landing ? ld_id : to_id;
                    grant_id               <= grant_landing ? ld_id : to_id;
                    timer[grant_runway]    <= TIMER_LOAD;
                    owned[grant_runway]    <= 1'b1;
                    reserved[grant_runway] <= 1'b0;
                    grant_valid            <= 1'b1;
                    state                  <= GRANT;
                end
                GRANT: begin
                    if (grant_ready) begin
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_runway_scheduler.sv
// Bench for runway_scheduler: directed scenarios then random traffic, every cycle
// compared against a queue-based reference model of the scheduling rules.
module tb_runway_scheduler;

    localparam int T  = 8;
    localparam int SL = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       to_valid, ld_valid, emergency;
    logic [3:0] to_id, ld_id;
    logic       to_pop, ld_pop;
    logic       rel_valid, rel_runway;
    logic [3:0] rel_id;
    logic       grant_valid, grant_runway, grant_landing, grant_ready;
    logic [3:0] grant_id;
    logic [1:0] runway_busy;
    logic       timeout_valid, timeout_runway;
    logic [3:0] timeout_id;

    runway_scheduler #(.TIMEOUT_CYCLES(T), .STARVE_LIMIT(SL)) dut (
        .clock(clock), .reset(reset),
        .to_valid(to_valid), .to_id(to_id), .to_pop(to_pop),
        .ld_valid(ld_valid), .ld_id(ld_id), .ld_pop(ld_pop),
        .emergency(emergency),
        .rel_valid(rel_valid), .rel_runway(rel_runway), .rel_id(rel_id),
        .grant_valid(grant_valid), .grant_id(grant_id), .grant_runway(grant_runway),
        .grant_landing(grant_landing), .grant_ready(grant_ready),
        .runway_busy(runway_busy),
        .timeout_valid(timeout_valid), .timeout_runway(timeout_runway), .timeout_id(timeout_id)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [3:0] to_q [$];
    logic [3:0] ld_q [$];

    // Reference model: plane bookkeeping per runway plus a handshake phase counter.
    int         m_phase = 0;
    bit         m_res [2];
    bit         m_own [2];
    logic [3:0] m_owner [2];
    int         m_left [2];
    int         m_starve = 0;
    bit         m_gv = 0;
    logic [3:0] m_gid = 0;
    bit         m_grwy = 0;
    bit         m_gland = 0;
    logic [3:0] m_pop_id = 0;
    bit         m_tv = 0;
    bit         m_tr = 0;
    logic [3:0] m_tid = 0;

    bit   auto_rel = 0;
    int   to_pop_seen, tv_seen, pick_cyc, tv_cyc;
    logic [3:0] tv_id_seen;
    logic order_q [$];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_phase = 0; m_starve = 0; m_gv = 0; m_tv = 0;
        for (int r = 0; r < 2; r++) begin
            m_res[r] = 0; m_own[r] = 0; m_left[r] = 0; m_owner[r] = 0;
        end
    endtask

    task automatic step();
        bit free0, free1, to_el, ld_el, pick, land, rwy, rel_ok, exp0, exp1;
        to_valid = (to_q.size() != 0);
        ld_valid = (ld_q.size() != 0);
        if (auto_rel) begin
            rel_valid = 0;
            for (int r = 0; r < 2; r++)
                if (m_own[r] && !rel_valid) begin
                    rel_valid = 1; rel_runway = 1'(r); rel_id = m_owner[r];
                end
        end
        @(negedge clock);
        free0 = !m_res[0] && !m_own[0];
        free1 = !m_res[1] && !m_own[1];
        to_el = to_valid && !emergency;
        ld_el = ld_valid;
        pick  = !reset && (m_phase == 0) && (free0 || free1) && (to_el || ld_el);
        land  = ld_el && (!to_el || (m_starve < SL));
        rwy   = !free0;
        check("to_pop", to_pop, pick && !land);
        check("ld_pop", ld_pop, pick && land);
        check("grant_valid", grant_valid, m_gv);
        if (m_gv) begin
            check("grant_id", grant_id, m_gid);
            check("grant_runway", grant_runway, m_grwy);
            check("grant_landing", grant_landing, m_gland);
        end
        check("runway_busy", runway_busy, {m_res[1] | m_own[1], m_res[0] | m_own[0]});
        check("timeout_valid", timeout_valid, m_tv);
        if (m_tv) begin
            check("timeout_runway", timeout_runway, m_tr);
            check("timeout_id", timeout_id, m_tid);
        end
        if (to_pop === 1'b1) begin to_pop_seen++; pick_cyc = cyc; end
        if (timeout_valid === 1'b1) begin tv_seen++; tv_cyc = cyc; tv_id_seen = timeout_id; end
        if (grant_valid === 1'b1 && grant_ready) order_q.push_back(grant_landing);
        @(posedge clock);
        if (reset) begin
            model_clear();
        end else begin
            rel_ok = rel_valid && m_own[rel_runway] && (rel_id == m_owner[rel_runway]);
            exp0 = m_own[0] && (m_left[0] == 1) && !(rel_ok && rel_runway == 0);
            exp1 = m_own[1] && (m_left[1] == 1) && !(rel_ok && rel_runway == 1);
            m_tv  = exp0 || exp1;
            m_tr  = !exp0;
            m_tid = exp0 ? m_owner[0] : m_owner[1];
            for (int r = 0; r < 2; r++) begin
                if (rel_ok && int'(rel_runway) == r) begin m_own[r] = 0; m_left[r] = 0; end
                else if ((r == 0 && exp0) || (r == 1 && exp1 && !exp0)) m_own[r] = 0;
                else if (m_own[r] && m_left[r] > 1) m_left[r]--;
            end
            case (m_phase)
                0: if (pick) begin
                    m_phase = 1; m_res[rwy] = 1; m_grwy = rwy; m_gland = land;
                    if (land) begin
                        m_pop_id = ld_q.pop_front();
                        if (to_el && m_starve < SL) m_starve++;
                    end else begin
                        m_pop_id = to_q.pop_front();
                        m_starve = 0;
                    end
                end
                1: begin
                    m_owner[m_grwy] = m_pop_id; m_gid = m_pop_id; m_left[m_grwy] = T;
                    m_own[m_grwy] = 1; m_res[m_grwy] = 0; m_gv = 1; m_phase = 2;
                end
                default: if (grant_ready) begin m_phase = 0; m_gv = 0; end
            endcase
        end
        cyc++;
        #1;
        if (!reset && pick) begin
            if (land) ld_id = m_pop_id; else to_id = m_pop_id;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic release_rwy(input logic r, input logic [3:0] id);
        rel_valid = 1; rel_runway = r; rel_id = id;
        step();
        rel_valid = 0;
    endtask

    initial begin
        logic [7:0] exp_order;
        logic       got_ord;
        reset = 1; to_valid = 0; ld_valid = 0; to_id = 0; ld_id = 0; emergency = 0;
        rel_valid = 0; rel_runway = 0; rel_id = 0; grant_ready = 1;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        steps(2);
        reset = 0;

        // Takeoff only
        to_q.push_back(4'd5);
        steps(2);
        check("t1_grant_valid", grant_valid, 1);
        check("t1_grant_id", grant_id, 5);
        check("t1_grant_runway", grant_runway, 0);
        check("t1_grant_landing", grant_landing, 0);
        check("t1_busy", runway_busy, 2'b01);
        step();
        release_rwy(0, 4'd5);
        steps(2);

        // Both runways busy, correct release, bogus release
        to_q.push_back(4'd3); to_q.push_back(4'd7); to_q.push_back(4'd11);
        steps(5);
        release_rwy(0, 4'd3);
        step();
        release_rwy(1, 4'd9);
        check("t2_busy_after_bad_release", runway_busy, 2'b11);
        steps(20);

        // Starvation ordering
        auto_rel = 1;
        order_q.delete();
        for (int i = 0; i < 8; i++) begin
            ld_q.push_back(4'(i)); to_q.push_back(4'(8 + i));
        end
        steps(60);
        exp_order = 8'b0111_0111;
        check("t3_order_len", order_q.size() >= 8, 1);
        for (int i = 0; i < 8; i++) begin
            got_ord = (i < order_q.size()) ? order_q[i] : 1'bx;
            check($sformatf("t3_order_%0d", i), got_ord, exp_order[i]);
        end

        // Emergency blocks takeoffs
        emergency = 1;
        to_pop_seen = 0;
        for (int i = 0; i < 3; i++) begin
            ld_q.push_back(4'(1 + i)); to_q.push_back(4'(12 + i));
        end
        steps(15);
        check("t4_to_pop_in_emergency", 8'(to_pop_seen), 0);
        emergency = 0;
        steps(15);
        check("t4_to_pops_after", 8'(to_pop_seen), 3);
        steps(5);

        // Watchdog expiry
        auto_rel = 0;
        tv_seen = 0; pick_cyc = -100; tv_cyc = 0;
        to_q.push_back(4'd2);
        steps(20);
        check("t5_timeout_count", 8'(tv_seen), 1);
        check("t5_timeout_delay", 8'(tv_cyc - pick_cyc), 10);
        check("t5_timeout_id", tv_id_seen, 2);
        check("t5_busy", runway_busy, 2'b00);

        // Release in the expiry cycle
        tv_seen = 0;
        to_q.push_back(4'd2);
        steps(9);
        release_rwy(0, 4'd2);
        steps(5);
        check("t6_timeout_count", 8'(tv_seen), 0);
        check("t6_busy", runway_busy, 2'b00);

        // Reset during GRANT
        to_q.push_back(4'd4);
        steps(2);
        grant_ready = 0;
        reset = 1;
        step();
        check("t7_grant_valid", grant_valid, 0);
        check("t7_busy", runway_busy, 2'b00);
        reset = 0;
        grant_ready = 1;
        steps(3);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0 && to_q.size() < 5) to_q.push_back(4'($urandom));
            if ($urandom_range(0, 3) == 0 && ld_q.size() < 5) ld_q.push_back(4'($urandom));
            if ($urandom_range(0, 9) == 0) emergency = ~emergency;
            grant_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) begin
                rel_valid  = 1;
                rel_runway = 1'($urandom);
                rel_id     = ($urandom_range(0, 1) == 1) ? m_owner[rel_runway] : 4'($urandom);
            end else begin
                rel_valid = 0;
            end
            reset = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
